sm_addsub_accumulator: RTL and testbench

- Sequential sign-magnitude accumulator for the MLP datapath, 21-bit format: bit 20 = sign, bits 19:0 = magnitude.
- Accepts a stream of operands. Each operand is added to or subtracted from a running sum, then one result is returned per frame.
- Serves as the subtracting/accumulating counterpart of the combinational sign-magnitude adder, for neuron weighted-sum and error-term calculation.

---
 rtl/sm_addsub_accumulator_if.sv | 43 ++++
 rtl/sm_addsub_accumulator.sv | 139 +++++++++++++
 tb/tb_sm_addsub_accumulator.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_addsub_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : sm_addsub_accumulator_if
// Description : Handshake and data bundle for the sign-magnitude accumulator.
//               Groups the frame start, the operand stream and the result
//               stream. The master modport is the stimulus side and the slave
//               modport is the accumulator side.
//   start      : begins a frame (honoured only while the block is idle)
//   in_valid   : operand valid           in_ready  : operand accepted
//   in_data    : sign-magnitude operand  in_sub    : negate operand
//   in_last    : final operand of frame
//   out_valid  : result valid            out_ready : result taken
//   out_data   : sign-magnitude result   out_ovf   : sticky saturation flag
//   out_count  : operands accepted in the frame (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
interface sm_addsub_accumulator_if #(
    parameter int MAG_W = 20,
    parameter int CNT_W = 8
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [MAG_W:0]   in_data;
    logic             in_sub;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [MAG_W:0]   out_data;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    modport master (
        output start, in_valid, in_data, in_sub, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_count
    );

    modport slave (
        input  start, in_valid, in_data, in_sub, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_count
    );
endinterface
`default_nettype wire

// File: rtl/sm_addsub_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sm_addsub_accumulator
// Description : Sequential sign-magnitude accumulator. A frame is opened by
//               start, accepts one operand per cycle (each added or
//               subtracted), and returns one saturated sign-magnitude sum
//               together with a sticky overflow flag and an operand count.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of sm_addsub_accumulator_if (operands in, result out)
// Revision    : 1.0 - initial release
// ============================================================================
module sm_addsub_accumulator #(
    parameter int MAG_W = 20,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sm_addsub_accumulator_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_acc_sign;
    logic [MAG_W-1:0]   r_acc_mag;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_count;

    logic [MAG_W-1:0]   w_op_mag;
    logic               w_op_sign;
    logic [MAG_W:0]     w_sum;
    logic [MAG_W-1:0]   w_res_mag;
    logic               w_res_sign;
    logic               w_res_sat;
    logic               w_accept;

    // Effective operand: sign flipped for subtraction, and a zero magnitude
    // always carries a positive sign so -0 can never enter the accumulator.
    assign w_op_mag  = bus.in_data[MAG_W-1:0];
    assign w_op_sign = (bus.in_data[MAG_W] ^ bus.in_sub) & (|w_op_mag);

    // One extra bit so the carry out of a same-sign add is visible.
    assign w_sum     = {1'b0, r_acc_mag} + {1'b0, w_op_mag};

    assign w_accept  = bus.in_valid & r_in_ready;

    always_comb begin
        w_res_mag  = r_acc_mag;
        w_res_sign = r_acc_sign;
        w_res_sat  = 1'b0;
        if (r_acc_sign == w_op_sign) begin
            // Same sign: magnitudes add; clamp to full scale on carry.
            w_res_sign = r_acc_sign;
            if (w_sum[MAG_W]) begin
                w_res_mag = '1;
                w_res_sat = 1'b1;
            end else begin
                w_res_mag = w_sum[MAG_W-1:0];
            end
        end else if (r_acc_mag >= w_op_mag) begin
            // Opposite signs, accumulator dominates. Exact cancellation is
            // forced to +0.
            w_res_mag  = r_acc_mag - w_op_mag;
            w_res_sign = (r_acc_mag == w_op_mag) ? 1'b0 : r_acc_sign;
        end else begin
            w_res_mag  = w_op_mag - r_acc_mag;
            w_res_sign = w_op_sign;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc_sign  <= 1'b0;
            r_acc_mag   <= '0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc_sign <= 1'b0;
                        r_acc_mag  <= '0;
                        r_ovf      <= 1'b0;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                        r_state    <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        r_acc_sign <= w_res_sign;
                        r_acc_mag  <= w_res_mag;
                        // Saturation is sticky until the next frame opens.
                        r_ovf      <= r_ovf | w_res_sat;
                        if (r_count != {CNT_W{1'b1}}) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (bus.in_last) begin
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    // Accumulator, flag and count are frozen here, so the
                    // result registers stay stable until the handshake.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = {r_acc_sign, r_acc_mag};
    assign bus.out_ovf   = r_ovf;
    assign bus.out_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sm_addsub_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_addsub_accumulator
// Description : Self-checking bench for sm_addsub_accumulator. Directed frame
//               vectors from a table, hand-written backpressure and
//               mid-frame reset sequences, and random frames checked against
//               a signed-integer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_addsub_accumulator;

    localparam int MAG_W   = 20;
    localparam int CNT_W   = 8;
    localparam longint MAX = (64'd1 << MAG_W) - 1;

    logic clk;
    logic rst_n;

    sm_addsub_accumulator_if #(.MAG_W(MAG_W), .CNT_W(CNT_W)) bus ();

    sm_addsub_accumulator #(.MAG_W(MAG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    logic [MAG_W:0] q_d[$];
    bit             q_s[$];

    typedef struct {
        int               n;
        logic [3:0][20:0] d;
        logic [3:0]       s;
        logic [20:0]      exp_d;
        bit               exp_o;
        int               exp_c;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: treat the running sum as a plain signed integer clamped to
    // +/- full scale; convert back to sign-magnitude at the end.
    function automatic void model(output logic [MAG_W:0] d, output bit o, output int c);
        longint v;
        longint op;
        v = 0;
        o = 1'b0;
        foreach (q_d[i]) begin
            op = longint'(q_d[i][MAG_W-1:0]);
            if (q_d[i][MAG_W] ^ q_s[i]) op = -op;
            v = v + op;
            if (v > MAX)  begin v = MAX;  o = 1'b1; end
            if (v < -MAX) begin v = -MAX; o = 1'b1; end
        end
        if (v < 0) d = {1'b1, MAG_W'(-v)};
        else       d = {1'b0, MAG_W'(v)};
        c = (q_d.size() > 255) ? 255 : q_d.size();
    endfunction

    task automatic run_frame(input string name, input logic [MAG_W:0] exp_d,
                             input bit exp_o, input int exp_c, input int hold, input bit gaps);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check({name, ".ready_acc"}, 32'(bus.in_ready), 32'd1);
        check({name, ".valid_acc"}, 32'(bus.out_valid), 32'd0);
        foreach (q_d[i]) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 21'($urandom);
                step();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = q_d[i];
            bus.in_sub   = q_s[i];
            bus.in_last  = (i == q_d.size() - 1);
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check({name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, ".in_ready"},  32'(bus.in_ready),  32'd0);
        check({name, ".data"},      32'(bus.out_data),  32'(exp_d));
        check({name, ".ovf"},       32'(bus.out_ovf),   32'(exp_o));
        check({name, ".count"},     32'(bus.out_count), 32'(exp_c));
        // Stalled output: stray start/in_valid must not disturb the result.
        for (int k = 0; k < hold; k++) begin
            bus.start    = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_data  = 21'($urandom);
            bus.in_last  = 1'b1;
            step();
            check({name, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({name, ".hold_ready"}, 32'(bus.in_ready),  32'd0);
            check({name, ".hold_data"},  32'(bus.out_data),  32'(exp_d));
            check({name, ".hold_count"}, 32'(bus.out_count), 32'(exp_c));
        end
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({name, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({name, ".ready_idle"}, 32'(bus.in_ready),  32'd0);
        step();
    endtask

    initial begin
        logic [MAG_W:0] ed;
        bit             eo;
        int             ec;
        int             n;
        logic [MAG_W-1:0] m;

        n_cmp = 0;
        n_err = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sub    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        tbl[0] = '{3, {21'h0, 21'h100002, 21'h000003, 21'h000005}, 4'b0000, 21'h000006, 1'b0, 3};
        tbl[1] = '{2, {21'h0, 21'h0,      21'h00000A, 21'h000004}, 4'b0010, 21'h100006, 1'b0, 2};
        tbl[2] = '{2, {21'h0, 21'h0,      21'h000007, 21'h000007}, 4'b0010, 21'h000000, 1'b0, 2};
        tbl[3] = '{2, {21'h0, 21'h0,      21'h100000, 21'h100000}, 4'b0010, 21'h000000, 1'b0, 2};
        tbl[4] = '{3, {21'h0, 21'h000002, 21'h000001, 21'h0FFFFF}, 4'b0100, 21'h0FFFFD, 1'b1, 3};
        tbl[5] = '{2, {21'h0, 21'h0,      21'h000001, 21'h0FFFFF}, 4'b0000, 21'h0FFFFF, 1'b1, 2};
        tbl[6] = '{1, {21'h0, 21'h0,      21'h0,      21'h100009}, 4'b0001, 21'h000009, 1'b0, 1};
        tbl[7] = '{2, {21'h0, 21'h0,      21'h100010, 21'h1FFFFF}, 4'b0000, 21'h1FFFFF, 1'b1, 2};

        #3;
        check("rst.in_ready",  32'(bus.in_ready),  32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_data",  32'(bus.out_data),  32'd0);
        check("rst.out_ovf",   32'(bus.out_ovf),   32'd0);
        check("rst.out_count", 32'(bus.out_count), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Stray out_ready in IDLE has no effect.
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("idle.out_valid", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            q_d.delete();
            q_s.delete();
            for (int j = 0; j < tbl[i].n; j++) begin
                q_d.push_back(tbl[i].d[j]);
                q_s.push_back(tbl[i].s[j]);
            end
            run_frame($sformatf("vec%0d", i), tbl[i].exp_d, tbl[i].exp_o, tbl[i].exp_c,
                      (i == 0) ? 5 : 0, 1'b0);
        end

        // Asynchronous reset in the middle of an accumulating frame.
        bus.start = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sub   = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 21'd100;
        step();
        bus.in_data  = 21'd200;
        step();
        bus.in_valid = 1'b0;
        check("midrst.count_before", 32'(bus.out_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.in_ready",  32'(bus.in_ready),  32'd0);
        check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst.out_data",  32'(bus.out_data),  32'd0);
        check("midrst.out_ovf",   32'(bus.out_ovf),   32'd0);
        check("midrst.out_count", 32'(bus.out_count), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        q_d.delete();
        q_s.delete();
        q_d.push_back(21'd1);
        q_s.push_back(1'b0);
        run_frame("postrst", 21'd1, 1'b0, 1, 0, 1'b0);

        // Random frames against the reference model.
        for (int f = 0; f < 25; f++) begin
            q_d.delete();
            q_s.delete();
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) begin
                case ($urandom_range(0, 3))
                    0:       m = MAG_W'($urandom_range(0, 3));
                    1:       m = MAG_W'(MAX) - MAG_W'($urandom_range(0, 7));
                    default: m = MAG_W'($urandom);
                endcase
                q_d.push_back({1'($urandom), m});
                q_s.push_back(1'($urandom));
            end
            model(ed, eo, ec);
            run_frame($sformatf("rnd%0d", f), ed, eo, ec, $urandom_range(0, 2), 1'b1);
        end

        // Long frame: operand count must stop at its maximum.
        q_d.delete();
        q_s.delete();
        for (int j = 0; j < 300; j++) begin
            q_d.push_back({1'($urandom), MAG_W'($urandom_range(0, 5000))});
            q_s.push_back(1'($urandom));
        end
        model(ed, eo, ec);
        run_frame("long", ed, eo, ec, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
